// File: rtl/ej32_pkg.sv
// Shared types for the ej32 SPRAM arbiter: requester ids, arbiter states and
// the longest burst length (beats-1) a requester may ask for.
package ej32_pkg;
  typedef enum logic [1:0] {
    RQ_NONE = 2'd0,
    RQ_BOOT = 2'd1,
    RQ_LS   = 2'd2,
    RQ_IF   = 2'd3
  } arb_id_t;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_st_t;

  localparam logic [1:0] ARB_MAXLEN = 2'd3;
endpackage

// File: rtl/ej32_arb_chk.sv
// Protocol checks for ej32_mem_arb: one grant and one ack per cycle at most,
// and the beat index never exceeds the longest burst.
module ej32_arb_chk
  import ej32_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic [2:0] gnt,
  input logic [2:0] ack,
  input logic [1:0] beat
);
  a_one_gnt: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_one_ack: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  a_beat_rng: assert property (@(posedge clk) disable iff (rst) beat <= ARB_MAXLEN);
endmodule

// File: rtl/ej32_arb_pick.sv
// Combinational requester select: BOOT while the loader is active, then IF once
// LS has starved it for MAXB bursts, then LS, then IF.
module ej32_arb_pick
  import ej32_pkg::*;
#(
  parameter int MAXB = 4,
  parameter int LSCW = 3
) (
  input  logic            boot_act,
  input  logic            boot_req,
  input  logic            ls_req,
  input  logic            if_req,
  input  logic [LSCW-1:0] lsc,
  output logic [1:0]      pick
);
  localparam logic [LSCW-1:0] MAXB_C = LSCW'(MAXB);

  // priority chain; boot_req is ignored unless the loader is active
  always_comb begin
    pick = RQ_NONE;
    if (boot_act && boot_req) begin
      pick = RQ_BOOT;
    end else if (if_req && (lsc == MAXB_C)) begin
      pick = RQ_IF;
    end else if (ls_req) begin
      pick = RQ_LS;
    end else if (if_req) begin
      pick = RQ_IF;
    end else begin
      pick = RQ_NONE;
    end
  end
endmodule

// File: rtl/ej32_mem_arb.sv
// Burst arbiter for the shared 8-bit SPRAM bus. Beat 0 goes out in the grant
// cycle; read data returns a cycle later and is routed by a delayed owner tag.
module ej32_mem_arb
  import ej32_pkg::*;
#(
  parameter int ASZ  = 17,
  parameter int MAXB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           boot_act,
  input  logic           boot_req,
  input  logic           boot_we,
  input  logic [ASZ-1:0] boot_a,
  input  logic [1:0]     boot_len,
  input  logic [7:0]     boot_wd,
  output logic           boot_gnt,
  output logic           boot_ack,
  input  logic           ls_req,
  input  logic           ls_we,
  input  logic [ASZ-1:0] ls_a,
  input  logic [1:0]     ls_len,
  input  logic [7:0]     ls_wd,
  output logic           ls_gnt,
  output logic           ls_ack,
  input  logic           if_req,
  input  logic           if_we,
  input  logic [ASZ-1:0] if_a,
  input  logic [1:0]     if_len,
  input  logic [7:0]     if_wd,
  output logic           if_gnt,
  output logic           if_ack,
  output logic [1:0]     beat,
  output logic [1:0]     own,
  output logic [7:0]     rd,
  output logic [ASZ-1:0] mem_a,
  output logic           mem_we,
  output logic [7:0]     mem_vi,
  input  logic [7:0]     mem_vo,
  output logic           bsy
);
  localparam int LSCW = $clog2(MAXB + 1);
  localparam logic [LSCW-1:0] MAXB_C = LSCW'(MAXB);

  arb_st_t        state_r, state_nx_s;
  arb_id_t        own_r, tag_r, pick_s, cur_own_s;
  logic [1:0]     pick_raw_s, len_r, cnt_r, sel_len_s, cur_beat_s;
  logic [ASZ-1:0] base_r, hold_r, sel_a_s, cur_a_s;
  logic [LSCW-1:0] lsc_r;
  logic           we_r, sel_we_s, cur_we_s, gnt_s, active_s;
  logic [7:0]     cur_wd_s;

  ej32_arb_pick #(.MAXB(MAXB), .LSCW(LSCW)) u_pick (
    .boot_act (boot_act),
    .boot_req (boot_req),
    .ls_req   (ls_req),
    .if_req   (if_req),
    .lsc      (lsc_r),
    .pick     (pick_raw_s)
  );

  assign pick_s = arb_id_t'(pick_raw_s);
  assign gnt_s  = !rst && (state_r == ARB_IDLE) && (pick_s != RQ_NONE);

  // burst parameters of the requester being selected
  always_comb begin
    sel_we_s  = 1'b0;
    sel_a_s   = {ASZ{1'b0}};
    sel_len_s = 2'd0;
    case (pick_s)
      RQ_BOOT: begin sel_we_s = boot_we; sel_a_s = boot_a; sel_len_s = boot_len; end
      RQ_LS:   begin sel_we_s = ls_we;   sel_a_s = ls_a;   sel_len_s = ls_len;   end
      RQ_IF:   begin sel_we_s = if_we;   sel_a_s = if_a;   sel_len_s = if_len;   end
      default: begin sel_we_s = 1'b0;    sel_a_s = {ASZ{1'b0}}; sel_len_s = 2'd0; end
    endcase
  end

  // what is on the bus this cycle: beat 0 straight from the inputs, later beats from latches
  always_comb begin
    cur_own_s  = RQ_NONE;
    cur_a_s    = hold_r;
    cur_we_s   = 1'b0;
    cur_beat_s = 2'd0;
    active_s   = 1'b0;
    if (rst) begin
      cur_a_s = {ASZ{1'b0}};
    end else if (gnt_s) begin
      cur_own_s = pick_s;
      cur_a_s   = sel_a_s;
      cur_we_s  = sel_we_s;
      active_s  = 1'b1;
    end else if (state_r == ARB_BURST) begin
      cur_own_s  = own_r;
      cur_a_s    = base_r + ASZ'(cnt_r);
      cur_we_s   = we_r;
      cur_beat_s = cnt_r;
      active_s   = 1'b1;
    end else begin
      cur_own_s = RQ_NONE;
    end
  end

  // write byte comes live from the bus owner on every beat
  always_comb begin
    cur_wd_s = 8'h00;
    case (cur_own_s)
      RQ_BOOT: cur_wd_s = boot_wd;
      RQ_LS:   cur_wd_s = ls_wd;
      RQ_IF:   cur_wd_s = if_wd;
      default: cur_wd_s = 8'h00;
    endcase
  end

  // next state: a burst of more than one beat parks in BURST until its last beat
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (gnt_s && (sel_len_s != 2'd0)) state_nx_s = ARB_BURST;
        else                              state_nx_s = ARB_IDLE;
      end
      ARB_BURST: begin
        if (cnt_r == len_r) state_nx_s = ARB_IDLE;
        else                state_nx_s = ARB_BURST;
      end
      default: state_nx_s = ARB_IDLE;
    endcase
  end

  // read data and acks belong to whoever issued the address last cycle
  always_comb begin
    if (rst || (tag_r == RQ_NONE)) rd = 8'h00;
    else                           rd = mem_vo;
  end

  assign boot_gnt = gnt_s && (pick_s == RQ_BOOT);
  assign ls_gnt   = gnt_s && (pick_s == RQ_LS);
  assign if_gnt   = gnt_s && (pick_s == RQ_IF);
  assign boot_ack = !rst && (tag_r == RQ_BOOT);
  assign ls_ack   = !rst && (tag_r == RQ_LS);
  assign if_ack   = !rst && (tag_r == RQ_IF);
  assign beat     = cur_beat_s;
  assign own      = cur_own_s;
  assign mem_a    = cur_a_s;
  assign mem_we   = cur_we_s;
  assign mem_vi   = cur_we_s ? cur_wd_s : 8'h00;
  assign bsy      = !rst && ((state_r == ARB_BURST) || gnt_s);

  // state, burst latches, fairness counter and read-ack tag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
      own_r   <= RQ_NONE;
      tag_r   <= RQ_NONE;
      base_r  <= {ASZ{1'b0}};
      hold_r  <= {ASZ{1'b0}};
      len_r   <= 2'd0;
      cnt_r   <= 2'd0;
      we_r    <= 1'b0;
      lsc_r   <= {LSCW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (gnt_s) begin
        own_r  <= pick_s;
        base_r <= sel_a_s;
        len_r  <= sel_len_s;
        we_r   <= sel_we_s;
        cnt_r  <= 2'd1;
      end else if (state_r == ARB_BURST) begin
        cnt_r <= cnt_r + 2'd1;
        if (cnt_r == len_r) own_r <= RQ_NONE;
      end
      if (active_s) hold_r <= cur_a_s;
      tag_r <= (active_s && !cur_we_s) ? cur_own_s : RQ_NONE;
      // IF is forced after MAXB LS grants that found it waiting
      if (!if_req) begin
        lsc_r <= {LSCW{1'b0}};
      end else if (gnt_s && (pick_s == RQ_IF)) begin
        lsc_r <= {LSCW{1'b0}};
      end else if (gnt_s && (pick_s == RQ_LS) && (lsc_r != MAXB_C)) begin
        lsc_r <= lsc_r + LSCW'(1'b1);
      end
    end
  end

  ej32_arb_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .gnt  ({boot_gnt, ls_gnt, if_gnt}),
    .ack  ({boot_ack, ls_ack, if_ack}),
    .beat (beat)
  );
endmodule

// File: tb/tb_ej32_mem_arb.sv
// Directed bench for ej32_mem_arb with a registered-read SPRAM model.
module tb_ej32_mem_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        boot_act = 1'b0, boot_req = 1'b0, boot_we = 1'b0;
  logic [16:0] boot_a = 17'd0;
  logic [1:0]  boot_len = 2'd0;
  logic [7:0]  boot_wd = 8'd0;
  logic        ls_req = 1'b0, ls_we = 1'b0;
  logic [16:0] ls_a = 17'd0;
  logic [1:0]  ls_len = 2'd0;
  logic [7:0]  ls_wd = 8'd0;
  logic        if_req = 1'b0, if_we = 1'b0;
  logic [16:0] if_a = 17'd0;
  logic [1:0]  if_len = 2'd0;
  logic [7:0]  if_wd = 8'd0;
  logic        boot_gnt, boot_ack, ls_gnt, ls_ack, if_gnt, if_ack, mem_we, bsy;
  logic [1:0]  beat, own;
  logic [7:0]  rd, mem_vi;
  logic [7:0]  mem_vo;
  logic [16:0] mem_a;
  logic [7:0]  ram [0:131071];
  logic [9:0]  exp_if;
  int          n_chk = 0;
  int          n_pass = 0;

  ej32_mem_arb #(.ASZ(17), .MAXB(4)) dut (
    .clk(clk), .rst(rst), .boot_act(boot_act),
    .boot_req(boot_req), .boot_we(boot_we), .boot_a(boot_a), .boot_len(boot_len),
    .boot_wd(boot_wd), .boot_gnt(boot_gnt), .boot_ack(boot_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_a(ls_a), .ls_len(ls_len),
    .ls_wd(ls_wd), .ls_gnt(ls_gnt), .ls_ack(ls_ack),
    .if_req(if_req), .if_we(if_we), .if_a(if_a), .if_len(if_len),
    .if_wd(if_wd), .if_gnt(if_gnt), .if_ack(if_ack),
    .beat(beat), .own(own), .rd(rd), .mem_a(mem_a), .mem_we(mem_we),
    .mem_vi(mem_vi), .mem_vo(mem_vo), .bsy(bsy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_a] <= mem_vi;
    mem_vo <= ram[mem_a];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ls_write(input logic [16:0] a, input logic [1:0] len, input logic [31:0] dw);
    logic [16:0] ea;
    ls_req = 1'b1; ls_we = 1'b1; ls_a = a; ls_len = len;
    for (int k = 0; k <= int'(len); k++) begin
      ls_wd = dw[8*k +: 8];
      ea = a + 17'(k);
      @(negedge clk);
      chk("wr_gnt", 32'(ls_gnt), 32'(k == 0));
      chk("wr_we", 32'(mem_we), 32'd1);
      chk("wr_a", 32'(mem_a), 32'(ea));
      chk("wr_vi", 32'(mem_vi), 32'(dw[8*k +: 8]));
      chk("wr_beat", 32'(beat), 32'(k));
      tick();
      ls_req = 1'b0;
    end
  endtask

  task automatic ls_read(input logic [16:0] a, input logic [1:0] len, input logic [31:0] dw);
    ls_req = 1'b1; ls_we = 1'b0; ls_a = a; ls_len = len;
    @(negedge clk);
    chk("rd_gnt", 32'(ls_gnt), 32'd1);
    chk("rd_we", 32'(mem_we), 32'd0);
    chk("rd_ack0", 32'(ls_ack), 32'd0);
    tick();
    ls_req = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      @(negedge clk);
      chk("rd_ack", 32'(ls_ack), 32'd1);
      chk("rd_data", 32'(rd), 32'(dw[8*k +: 8]));
      tick();
    end
    @(negedge clk);
    chk("rd_ack_end", 32'(ls_ack), 32'd0);
    tick();
  endtask

  initial begin
    // T1: reset, then reset again in the middle of a 4-byte LS write
    tick();
    tick();
    @(negedge clk);
    chk("rst_gnt", 32'({boot_gnt, ls_gnt, if_gnt}), 32'd0);
    chk("rst_ack", 32'({boot_ack, ls_ack, if_ack}), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_a", 32'(mem_a), 32'd0);
    chk("rst_vi", 32'(mem_vi), 32'd0);
    chk("rst_beat", 32'(beat), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_own", 32'(own), 32'd0);
    rst = 1'b0;
    tick();
    ls_req = 1'b1; ls_we = 1'b1; ls_a = 17'h00040; ls_len = 2'd3; ls_wd = 8'h77;
    @(negedge clk);
    chk("t1_gnt", 32'(ls_gnt), 32'd1);
    chk("t1_a0", 32'(mem_a), 32'h40);
    chk("t1_own", 32'(own), 32'd2);
    tick();
    ls_req = 1'b0;
    @(negedge clk);
    chk("t1_a1", 32'(mem_a), 32'h41);
    chk("t1_beat1", 32'(beat), 32'd1);
    chk("t1_bsy", 32'(bsy), 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t1_rst_we", 32'(mem_we), 32'd0);
    chk("t1_rst_a", 32'(mem_a), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t1_post_we", 32'(mem_we), 32'd0);
    chk("t1_post_own", 32'(own), 32'd0);
    chk("t1_post_bsy", 32'(bsy), 32'd0);
    chk("t1_post_beat", 32'(beat), 32'd0);
    chk("t1_post_ack", 32'(ls_ack), 32'd0);
    tick();
    chk("t1_ram41", 32'(ram[17'h00041]), 32'h77);

    // T2: boot copy while LS waits
    boot_act = 1'b1; boot_req = 1'b1; boot_we = 1'b1; boot_len = 2'd0;
    ls_req = 1'b1; ls_we = 1'b0; ls_a = 17'h00200; ls_len = 2'd0;
    for (int i = 0; i < 4; i++) begin
      boot_a = 17'(i);
      boot_wd = 8'hA5 + 8'(i);
      @(negedge clk);
      chk("t2_bgnt", 32'(boot_gnt), 32'd1);
      chk("t2_lgnt", 32'(ls_gnt), 32'd0);
      chk("t2_we", 32'(mem_we), 32'd1);
      chk("t2_a", 32'(mem_a), 32'(i));
      tick();
    end
    boot_req = 1'b0; boot_act = 1'b0; ls_req = 1'b0;
    chk("t2_ram0", 32'(ram[17'd0]), 32'hA5);
    chk("t2_ram1", 32'(ram[17'd1]), 32'hA6);
    chk("t2_ram2", 32'(ram[17'd2]), 32'hA7);
    chk("t2_ram3", 32'(ram[17'd3]), 32'hA8);
    tick();

    // T3: 4-byte write then 4-byte read at 0x0100
    ls_write(17'h00100, 2'd3, 32'h44332211);
    ls_read(17'h00100, 2'd3, 32'h44332211);

    // T4: write burst wrapping the top of the address space
    ls_write(17'h1FFFE, 2'd3, 32'hD4C3B2A1);
    chk("t4_ram_fffe", 32'(ram[17'h1FFFE]), 32'hA1);
    chk("t4_ram_ffff", 32'(ram[17'h1FFFF]), 32'hB2);
    chk("t4_ram_0", 32'(ram[17'h00000]), 32'hC3);
    chk("t4_ram_1", 32'(ram[17'h00001]), 32'hD4);
    tick();

    // T5: LS and IF both held, single-beat reads
    ls_req = 1'b1; ls_we = 1'b0; ls_a = 17'h00100; ls_len = 2'd0;
    if_req = 1'b1; if_we = 1'b0; if_a = 17'h00101; if_len = 2'd0;
    exp_if = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_ifgnt", 32'(if_gnt), 32'(exp_if[i]));
      chk("t5_lsgnt", 32'(ls_gnt), 32'(!exp_if[i]));
      chk("t5_own", 32'(own), exp_if[i] ? 32'd3 : 32'd2);
      tick();
    end
    ls_req = 1'b0; if_req = 1'b0;
    tick();

    // T6: IF 2-byte read, then LS write with no bubble
    if_req = 1'b1; if_we = 1'b0; if_a = 17'h00100; if_len = 2'd1;
    @(negedge clk);
    chk("t6_ifgnt", 32'(if_gnt), 32'd1);
    tick();
    if_req = 1'b0;
    ls_req = 1'b1; ls_we = 1'b1; ls_a = 17'h00300; ls_len = 2'd0; ls_wd = 8'h5A;
    @(negedge clk);
    chk("t6_lsgnt_early", 32'(ls_gnt), 32'd0);
    chk("t6_a1", 32'(mem_a), 32'h101);
    chk("t6_ack0", 32'(if_ack), 32'd1);
    chk("t6_rd0", 32'(rd), 32'h11);
    tick();
    @(negedge clk);
    chk("t6_lsgnt", 32'(ls_gnt), 32'd1);
    chk("t6_ack1", 32'(if_ack), 32'd1);
    chk("t6_rd1", 32'(rd), 32'h22);
    chk("t6_lsack", 32'(ls_ack), 32'd0);
    chk("t6_wa", 32'(mem_a), 32'h300);
    tick();
    ls_req = 1'b0;
    @(negedge clk);
    chk("t6_lsack_end", 32'(ls_ack), 32'd0);
    chk("t6_ifack_end", 32'(if_ack), 32'd0);
    tick();
    chk("t6_ram300", 32'(ram[17'h00300]), 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
